// File: rtl/port_clkstat.sv
// port_clkstat: PATLPP port that counts rising edges of the gated user clock
// (usr_clk, asynchronous to clk) and reports the count to the host.
//
// A query frame on the input port takes a snapshot of the edge counter. The
// port then answers with a 6-byte frame:
//   ID_BYTE, status {6'b0, act, ovf}, snapshot[31:24], [23:16], [15:8], [7:0]
// The eof byte of the query is the command: bit 0 = clear after read.
//
// Ports:
//   clk, rst           system clock; asynchronous active-low reset
//   en                 port select; gates acceptance of input bytes
//   in_data/in_sof/in_eof/in_src_rdy, in_dst_rdy     input frame handshake
//   out_data/out_sof/out_eof/out_src_rdy, out_dst_rdy response handshake
//   usr_clk            gated user clock to be counted (freq < clk/2)
module port_clkstat #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = 8'hC5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  input  logic       in_eof,
  input  logic       in_src_rdy,
  output logic       in_dst_rdy,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_src_rdy,
  input  logic       out_dst_rdy,
  input  logic       usr_clk
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             idx, idx_nxt;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;
  logic                   rise;
  logic [31:0]            count;
  logic [31:0]            snapshot;
  logic [7:0]             status;
  logic                   ovf;
  logic                   act;
  logic                   alive;
  logic                   accept;
  logic                   query;
  logic                   unused_inputs;

  // Start-of-frame and upper command bits carry no meaning for this port.
  assign unused_inputs = ^{in_sof, in_data[7:1]};

  // usr_clk synchronizer chain, then one history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], usr_clk};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign rise = sync_p0[SYNC_STAGES-1] & ~hist_p1;

  // Edge counter, sticky flags and query snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      ovf      <= 1'b0;
      act      <= 1'b0;
      snapshot <= '0;
      status   <= '0;
    end else begin
      if (query) begin
        // The snapshot excludes an edge seen in the query cycle; that edge
        // is carried into the counter and act so it is never lost.
        snapshot <= count;
        status   <= {6'b0, act, ovf};
        act      <= rise;
      end else if (rise) begin
        act <= 1'b1;
      end
      if (query && in_data[0]) begin
        count <= rise ? 32'd1 : 32'd0;
        ovf   <= 1'b0;
      end else if (rise) begin
        count <= count + 32'd1;
        if (count == 32'hFFFF_FFFF) ovf <= 1'b1;
      end
    end
  end

  // Control state register; alive holds in_dst_rdy low while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      alive <= 1'b1;
    end
  end

  // Next-state and handshake/output decode
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    in_dst_rdy  = 1'b0;
    out_src_rdy = 1'b0;
    out_data    = 8'h00;
    out_sof     = 1'b0;
    out_eof     = 1'b0;
    accept      = 1'b0;
    query       = 1'b0;
    case (state)
      IDLE: begin
        in_dst_rdy = alive;
        accept     = en & in_src_rdy & alive;
        query      = accept & in_eof;
        if (query) begin
          state_nxt = SEND;
          idx_nxt   = 3'd0;
        end
      end
      SEND: begin
        out_src_rdy = 1'b1;
        out_sof     = (idx == 3'd0);
        out_eof     = (idx == 3'd5);
        case (idx)
          3'd0:    out_data = ID_BYTE;
          3'd1:    out_data = status;
          3'd2:    out_data = snapshot[31:24];
          3'd3:    out_data = snapshot[23:16];
          3'd4:    out_data = snapshot[15:8];
          default: out_data = snapshot[7:0];
        endcase
        if (out_dst_rdy) begin
          if (idx == 3'd5) begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_port_clkstat.sv
// Testbench for port_clkstat: randomized usr_clk pulse trains and
// backpressure, checked against an event-level model of the counter.
module tb_port_clkstat;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sof = 1'b0;
  logic       in_eof = 1'b0;
  logic       in_src_rdy = 1'b0;
  logic       in_dst_rdy;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_src_rdy;
  logic       out_dst_rdy = 1'b1;
  logic       usr_clk = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_count;
  logic        m_ovf;
  logic        m_act;
  logic [7:0]  exp_b [6];
  logic [7:0]  got_b [6];

  port_clkstat #(.SYNC_STAGES(S), .ID_BYTE(8'hC5)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
    .usr_clk(usr_clk)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_count = 32'd0;
    m_ovf   = 1'b0;
    m_act   = 1'b0;
  endfunction

  function automatic void model_edge();
    if (m_count == 32'hFFFF_FFFF) m_ovf = 1'b1;
    m_count = m_count + 32'd1;
    m_act   = 1'b1;
  endfunction

  function automatic void model_query(input logic clr);
    exp_b[0] = 8'hC5;
    exp_b[1] = {6'b0, m_act, m_ovf};
    exp_b[2] = m_count[31:24];
    exp_b[3] = m_count[23:16];
    exp_b[4] = m_count[15:8];
    exp_b[5] = m_count[7:0];
    if (clr) begin
      m_count = 32'd0;
      m_ovf   = 1'b0;
    end
    m_act = 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  // period 0 picks a random legal period per pulse
  task automatic pulses(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      int p;
      p = (period == 0) ? int'($urandom_range(4, 10)) : period;
      usr_clk = 1'b1;
      repeat (p / 2) @(negedge clk);
      usr_clk = 1'b0;
      repeat (p - p / 2) @(negedge clk);
      model_edge();
    end
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic send_query(input logic [7:0] cmd);
    @(negedge clk);
    en = 1'b1; in_data = cmd; in_sof = 1'b1; in_eof = 1'b1; in_src_rdy = 1'b1;
    checks++;
    if (in_dst_rdy !== 1'b1) begin
      errors++;
      $display("FAIL query_ready: in_dst_rdy=%b required 1", in_dst_rdy);
    end
    @(negedge clk);
    in_src_rdy = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    checks++;
    if (out_src_rdy !== 1'b1) begin
      errors++;
      $display("FAIL resp_latency: out_src_rdy=%b required 1 one cycle after accept", out_src_rdy);
    end
  endtask

  // Receives nbytes response bytes starting at the current negedge.
  task automatic collect(input bit bp, input bit noise, input int nbytes);
    int k;
    int budget;
    logic       hold_v;
    logic [9:0] hold;
    k = 0; budget = 0; hold_v = 1'b0; hold = '0;
    while (k < nbytes && budget < 300) begin
      out_dst_rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (noise) begin
        en = ($urandom_range(0, 1) == 1);
        in_src_rdy = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_data = 8'h01;
      end
      checks++;
      if (out_src_rdy !== 1'b1 || in_dst_rdy !== 1'b0) begin
        errors++;
        $display("FAIL send_state byte%0d: out_src_rdy=%b in_dst_rdy=%b required 1/0", k, out_src_rdy, in_dst_rdy);
      end
      if (hold_v) begin
        checks++;
        if ({out_data, out_sof, out_eof} !== hold) begin
          errors++;
          $display("FAIL hold byte%0d: got %h required %h", k, {out_data, out_sof, out_eof}, hold);
        end
      end
      if (out_dst_rdy) begin
        got_b[k] = out_data;
        checks++;
        if (out_sof !== (k == 0) || out_eof !== (k == 5)) begin
          errors++;
          $display("FAIL flags byte%0d: sof=%b eof=%b required %b %b", k, out_sof, out_eof, k == 0, k == 5);
        end
        k++;
        hold_v = 1'b0;
        if (k == nbytes && noise) begin
          in_src_rdy = 1'b0; in_sof = 1'b0; in_eof = 1'b0; en = 1'b1;
        end
      end else begin
        hold_v = 1'b1;
        hold   = {out_data, out_sof, out_eof};
      end
      @(negedge clk);
      budget++;
    end
    out_dst_rdy = 1'b1;
    if (k < nbytes) begin
      checks++; errors++;
      $display("FAIL collect_timeout: got %0d bytes required %0d", k, nbytes);
    end
    if (nbytes == 6) begin
      checks++;
      if (out_src_rdy !== 1'b0 || in_dst_rdy !== 1'b1) begin
        errors++;
        $display("FAIL frame_end: out_src_rdy=%b in_dst_rdy=%b required 0/1", out_src_rdy, in_dst_rdy);
      end
    end
  endtask

  task automatic compare_frame(input string name);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL %s byte%0d: got %h required %h", name, i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({in_dst_rdy, out_data, out_sof, out_eof, out_src_rdy} !== 12'h000) begin
      errors++;
      $display("FAIL %s: in_dst_rdy=%b out_data=%h sof=%b eof=%b src_rdy=%b required all 0",
               name, in_dst_rdy, out_data, out_sof, out_eof, out_src_rdy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      usr_clk = ~usr_clk;
      if (i % 4 == 0) check_idle_outputs("reset_outputs");
    end
    usr_clk = 1'b0;
    repeat (S + 2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (in_dst_rdy !== 1'b1 || out_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_dst_rdy=%b out_src_rdy=%b required 1/0", in_dst_rdy, out_src_rdy);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_src_rdy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_frame: out_src_rdy=%b required 0", out_src_rdy);
      end
    end
  endtask

  task automatic test_basic();
    pulses(10, 8);
    send_query(8'h00); model_query(1'b0);
    collect(1'b0, 1'b0, 6); compare_frame("basic_count");
    send_query(8'h00); model_query(1'b0);
    collect(1'b0, 1'b0, 6); compare_frame("basic_requery");
    for (int r = 0; r < 3; r++) begin
      logic [7:0] cmd;
      cmd = 8'($urandom_range(0, 255));
      pulses(int'($urandom_range(0, 25)), 0);
      send_query(cmd); model_query(cmd[0]);
      collect(1'b0, 1'b0, 6); compare_frame("random_query");
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 2; r++) begin
      pulses(int'($urandom_range(1, 15)), 0);
      send_query(8'h00); model_query(1'b0);
      collect(1'b1, 1'b1, 6); compare_frame("backpressure");
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (out_src_rdy !== 1'b0) begin
          errors++;
          $display("FAIL bp_no_extra_frame: out_src_rdy=%b required 0", out_src_rdy);
        end
      end
    end
  endtask

  task automatic test_clear_edge();
    pulses(int'($urandom_range(2, 12)), 0);
    @(negedge clk);
    en = 1'b1; in_src_rdy = 1'b1; in_sof = 1'b1; in_eof = 1'b0; in_data = 8'h11;
    @(negedge clk);
    in_sof = 1'b0; in_data = 8'h22;
    @(negedge clk);
    // usr_clk rises now; its edge is detected in the cycle the eof is accepted
    usr_clk = 1'b1; in_data = 8'h33;
    @(negedge clk);
    in_src_rdy = 1'b0;
    repeat (S - 1) @(negedge clk);
    in_src_rdy = 1'b1; in_eof = 1'b1; in_data = 8'h01;
    checks++;
    if (in_dst_rdy !== 1'b1 || out_src_rdy !== 1'b0) begin
      errors++;
      $display("FAIL clear_prequery: in_dst_rdy=%b out_src_rdy=%b required 1/0", in_dst_rdy, out_src_rdy);
    end
    model_query(1'b1);
    model_edge();
    @(negedge clk);
    in_src_rdy = 1'b0; in_eof = 1'b0;
    usr_clk = 1'b0;
    checks++;
    if (out_src_rdy !== 1'b1) begin
      errors++;
      $display("FAIL clear_latency: out_src_rdy=%b required 1", out_src_rdy);
    end
    collect(1'b0, 1'b0, 6); compare_frame("clear_edge");
    repeat (S + 3) @(negedge clk);
    send_query(8'h00); model_query(1'b0);
    collect(1'b0, 1'b0, 6); compare_frame("after_clear");
  endtask

  task automatic test_overflow();
    repeat (4) @(negedge clk);
    force dut.count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.count;
    m_count = 32'hFFFF_FFFE;
    pulses(3, 0);
    send_query(8'h01); model_query(1'b1);
    collect(1'b0, 1'b0, 6); compare_frame("overflow");
    send_query(8'h00); model_query(1'b0);
    collect(1'b0, 1'b0, 6); compare_frame("overflow_cleared");
  endtask

  task automatic test_reset_mid();
    int n;
    pulses(int'($urandom_range(1, 10)), 0);
    send_query(8'h00); model_query(1'b0);
    collect(1'b0, 1'b0, 3);
    rst = 1'b0;
    #1;
    check_idle_outputs("reset_mid_outputs");
    model_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_mid_held");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_src_rdy !== 1'b0 || in_dst_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: out_src_rdy=%b in_dst_rdy=%b required 0/1", out_src_rdy, in_dst_rdy);
    end
    n = int'($urandom_range(0, 12));
    pulses(n, 0);
    send_query(8'h00); model_query(1'b0);
    collect(1'b0, 1'b0, 6); compare_frame("reset_mid_fresh");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_clear_edge();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
